// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode encodings, flag bit positions and the
// multiplier state type used by alu_pipe and alu_seq_mul.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_C   = 1;
    localparam int FLAG_V   = 2;
    localparam int FLAG_N   = 3;
    localparam int FLAG_ILL = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one partial product per clock.
// start is held high by the owner while its operand bundle waits; once the
// product is ready, dropping start releases the unit back to IDLE.
module alu_seq_mul
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    mul_state_e       state;
    mul_state_e       state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    // State register for the multiplier control FSM.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: load on start, WIDTH shift-add steps, then hold until released.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = BUSY;
            BUSY: if (cnt == CW'(WIDTH - 1)) state_next = DONE;
            DONE: if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on entry to BUSY, then add and shift once per cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (state == IDLE && start) begin
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (state == BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    assign busy    = (state == BUSY);
    assign done    = (state == DONE);
    assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage ALU with valid/ready on both sides.
// S1 registers the operand bundle, S2 registers Result/Flags.
// Define ALU_PIPE_MUL_EN to build the iterative multiplier (opcode MUL);
// without it MUL is reported as an illegal opcode.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] ArgA,
    input  logic [WIDTH-1:0] ArgB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       Flags
);

    localparam int SHW = $clog2(WIDTH);

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s1_done;
    logic             s1_advance;
    logic             accept;

    logic [WIDTH-1:0] res;
    logic [4:0]       flg;
    logic [WIDTH:0]   sum_ext;
    logic             carry;
    logic             ovf;
    logic             ill;
    logic [SHW-1:0]   shamt;

`ifdef ALU_PIPE_MUL_EN
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign mul_start = s1_valid && (s1_op == OP_MUL) && !s1_advance;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .Clk     (Clk),
        .Rst     (Rst),
        .start   (mul_start),
        .a       (s1_a),
        .b       (s1_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign s1_done = (s1_op != OP_MUL) || (mul_done && !mul_busy);
`else
    assign s1_done = 1'b1;
`endif

    // S1 leaves when its result is ready and S2 is empty or being drained.
    assign s1_advance = s1_valid && s1_done && (!OutValid || OutReady);
    assign InReady    = !s1_valid || s1_advance;
    assign accept     = InValid && InReady;
    assign shamt      = s1_b[SHW-1:0];

    // Single-cycle operations and flag generation for the bundle held in S1.
    always_comb begin
        res     = '0;
        sum_ext = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        ill     = 1'b0;
        case (s1_op)
            OP_ADD: begin
                sum_ext = {1'b0, s1_a} + {1'b0, s1_b};
                res     = sum_ext[WIDTH-1:0];
                carry   = sum_ext[WIDTH];
                ovf     = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                sum_ext = {1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH+1)'(1);
                res     = sum_ext[WIDTH-1:0];
                carry   = sum_ext[WIDTH];
                ovf     = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND:  res = s1_a & s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_SLL:  res = s1_a << shamt;
            OP_SRL:  res = s1_a >> shamt;
            OP_SRA:  res = $signed(s1_a) >>> shamt;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  res = mul_product;
`endif
            default: ill = 1'b1;
        endcase

        flg = '0;
        if (ill) begin
            flg[FLAG_ILL] = 1'b1;
            flg[FLAG_Z]   = 1'b1;
        end else begin
            flg[FLAG_Z] = (res == '0);
            flg[FLAG_C] = carry;
            flg[FLAG_V] = ovf;
            flg[FLAG_N] = res[WIDTH-1];
        end
    end

    // Operand register: load on accept, empty when the bundle moves on to S2.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= Op;
            s1_a     <= ArgA;
            s1_b     <= ArgB;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Output register: frozen while stalled, refilled from S1 or emptied on drain.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            OutValid <= 1'b0;
            Result   <= '0;
            Flags    <= '0;
        end else if (s1_advance) begin
            OutValid <= 1'b1;
            Result   <= res;
            Flags    <= flg;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule
